// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: triggered capture of the ADC channel A sample stream.
// Samples are written into a ring buffer while armed. A level/slope trigger,
// or a forced trigger, freezes a window of DEPTH samples that holds PRE
// samples before the trigger. The window is then streamed out over valid/ready.
module adc_capture_buffer #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int PRE    = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              triggered,
    output logic              done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREFILL = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_POST    = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;

    // Samples still to be written after the trigger sample itself.
    localparam int POST_N = DEPTH - PRE - 1;

    // Terminal counts; a value is only used when its phase actually exists.
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE);
    localparam logic [ADDR_W:0]   RD_TOTAL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   RD_LASTI  = (ADDR_W + 1)'(DEPTH - 1);

    logic [2:0]        state;
    logic [DATA_W-1:0] adc_q;
    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W:0]   rd_cnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_pend;
    logic              rd_last;

    logic capturing;
    logic level_hit;
    logic trig_hit;
    logic xfer;
    logic load_out;
    logic issue;

    assign capturing = (state == S_PREFILL) || (state == S_WAIT) || (state == S_POST);
    assign level_hit = trig_slope ? ((prev_q < trig_level) && (adc_q >= trig_level))
                                  : ((prev_q > trig_level) && (adc_q <= trig_level));
    assign trig_hit  = (state == S_WAIT) && (force_trig || level_hit);
    assign xfer      = out_valid && out_ready;
    // rd_data acts as a one-entry skid behind the output register: it moves
    // forward whenever the output is empty or being drained this cycle.
    assign load_out  = rd_pend && (!out_valid || out_ready);
    // A new read is only issued when the skid entry is free (or freeing), so
    // nothing is overwritten and nothing is read twice.
    assign issue     = (state == S_READ) && (rd_cnt != RD_TOTAL) && (!rd_pend || load_out);
    assign busy      = (state != S_IDLE);

    // Input registers: current and previous sample for the slope compare.
    always_ff @(posedge clk) begin
        adc_q  <= adc_data;
        prev_q <= adc_q;
    end

    // Ring buffer write port and synchronous read port.
    always_ff @(posedge clk) begin
        if (capturing) begin
            mem[wr_ptr] <= adc_q;
        end
        if (issue) begin
            rd_data <= mem[rd_ptr];
        end
    end

    // Capture/readout sequencing, pointers and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            rd_cnt    <= '0;
            rd_pend   <= 1'b0;
            rd_last   <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (capturing) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        wr_ptr    <= '0;
                        cnt       <= '0;
                        triggered <= 1'b0;
                        state     <= (PRE == 0) ? S_WAIT : S_PREFILL;
                    end
                end
                S_PREFILL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == PRE_LAST) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (trig_hit) begin
                        // Window start is fixed here: PRE samples before the
                        // trigger sample being written this cycle.
                        triggered <= 1'b1;
                        cnt       <= '0;
                        rd_ptr    <= wr_ptr - PRE_OFS;
                        rd_cnt    <= '0;
                        rd_pend   <= 1'b0;
                        state     <= (POST_N == 0) ? S_READ : S_POST;
                    end
                end
                S_POST: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == POST_LAST) begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        rd_cnt  <= rd_cnt + 1'b1;
                        rd_last <= (rd_cnt == RD_LASTI);
                        rd_pend <= 1'b1;
                    end else if (load_out) begin
                        rd_pend <= 1'b0;
                    end
                    if (xfer && out_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: loads from the skid entry, empties on a bare transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
            out_last  <= rd_last;
        end else if (xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer: two instances (PRE=4 and PRE=0, DEPTH=16)
// share the ADC stream. A window-level reference model predicts each captured
// window; a negedge monitor consumes the predictions as transfers occur.
module tb_adc_capture_buffer;

    localparam int DATA_W = 14;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int PRE0   = 4;
    localparam int PRE1   = 0;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] adc_data;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic [1:0]        arm;
    logic [1:0]        force_trig;
    logic [1:0]        out_ready;
    logic [1:0]        out_valid;
    logic [1:0]        out_last;
    logic [1:0]        busy;
    logic [1:0]        triggered;
    logic [1:0]        done;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;

    int n_checks = 0;
    int n_err    = 0;
    int adc_mode = 0;   // 0 ramp up, 1 ramp down, 2 hold, 3 random
    int rdy_pct  = 100;

    adc_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRE(PRE0)) u_dut0 (
        .clk(clk), .reset(reset), .adc_data(adc_data), .arm(arm[0]), .force_trig(force_trig[0]),
        .trig_level(trig_level), .trig_slope(trig_slope), .out_ready(out_ready[0]),
        .out_valid(out_valid[0]), .out_data(out_data0), .out_last(out_last[0]),
        .busy(busy[0]), .triggered(triggered[0]), .done(done[0])
    );

    adc_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRE(PRE1)) u_dut1 (
        .clk(clk), .reset(reset), .adc_data(adc_data), .arm(arm[1]), .force_trig(force_trig[1]),
        .trig_level(trig_level), .trig_slope(trig_slope), .out_ready(out_ready[1]),
        .out_valid(out_valid[1]), .out_data(out_data1), .out_last(out_last[1]),
        .busy(busy[1]), .triggered(triggered[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    task automatic chk(int u, string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL u%0d %s: got %0d, expected %0d", u, name, act, exp);
        end
    endtask

    // ---------------- reference model (posedge) ----------------
    // Every sample seen at a clock edge is recorded. A capture armed at edge N
    // writes hist[N], hist[N+1], ...; the k-th written sample (k >= PRE) is a
    // trigger if the slope rule holds between hist[N+k-1] and hist[N+k], or
    // force_trig is high on the edge that writes it. The window is then
    // hist[N+k-PRE .. N+k-PRE+DEPTH-1].
    logic [DATA_W-1:0] hist[$];
    logic [DATA_W:0]   exp_q[2][$];   // {last, data}
    bit                m_active[2];
    bit                m_trig[2];
    bit                m_pushed[2];
    int                m_arm[2];
    int                m_tk[2];
    int                m_dseen[2];

    // ---------------- monitor-owned state (negedge) ----------------
    int                mon_idx[2];
    int                done_cnt[2];
    bit                prev_done[2];
    bit                stall_prev[2];
    logic [DATA_W-1:0] hold_d[2];
    logic              hold_l[2];
    logic [DATA_W-1:0] got[2][$];

    always @(posedge clk) begin
        int e, k, pre;
        logic [DATA_W-1:0] pv, cv;
        bit hit;
        hist.push_back(adc_data);
        e = hist.size() - 1;
        for (int u = 0; u < 2; u++) begin
            pre = (u == 0) ? PRE0 : PRE1;
            if (!reset) begin
                m_active[u] = 0;
                m_trig[u]   = 0;
                m_tk[u]     = -1;
                m_pushed[u] = 0;
                m_dseen[u]  = done_cnt[u];
            end else begin
                if (done_cnt[u] != m_dseen[u]) begin
                    m_dseen[u]  = done_cnt[u];
                    m_active[u] = 0;
                end
                if (!m_active[u]) begin
                    if (arm[u]) begin
                        m_active[u] = 1;
                        m_trig[u]   = 0;
                        m_arm[u]    = e;
                        m_tk[u]     = -1;
                        m_pushed[u] = 0;
                    end
                end else if (m_tk[u] < 0) begin
                    k = e - m_arm[u] - 1;
                    if (k >= pre && e >= 2) begin
                        pv  = hist[e-2];
                        cv  = hist[e-1];
                        hit = force_trig[u] ||
                              (trig_slope ? (pv < trig_level && cv >= trig_level)
                                          : (pv > trig_level && cv <= trig_level));
                        if (hit) begin
                            m_tk[u]   = k;
                            m_trig[u] = 1;
                        end
                    end
                end
                if (m_active[u] && m_tk[u] >= 0 && !m_pushed[u] &&
                    e >= m_arm[u] + m_tk[u] + DEPTH - pre - 1) begin
                    for (int i = 0; i < DEPTH; i++)
                        exp_q[u].push_back({(i == DEPTH - 1), hist[m_arm[u] + m_tk[u] - pre + i]});
                    m_pushed[u] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [DATA_W-1:0] od;
        logic [DATA_W:0]   ex;
        for (int u = 0; u < 2; u++) begin
            od = (u == 0) ? out_data0 : out_data1;
            if (!reset) begin
                stall_prev[u] = 0;
                prev_done[u]  = 0;
                mon_idx[u]    = exp_q[u].size();
            end else begin
                if (done[u]) begin
                    done_cnt[u]++;
                    chk(u, "done_single_pulse", prev_done[u], 0);
                    chk(u, "done_window_complete", exp_q[u].size() - mon_idx[u], 0);
                end
                prev_done[u] = done[u];
                chk(u, "busy", busy[u], (m_active[u] && done_cnt[u] == m_dseen[u]) ? 1 : 0);
                chk(u, "triggered", triggered[u], m_trig[u]);
                if (stall_prev[u]) begin
                    chk(u, "stall_valid", out_valid[u], 1);
                    chk(u, "stall_data", od, hold_d[u]);
                    chk(u, "stall_last", out_last[u], hold_l[u]);
                end
                if (out_valid[u] && out_ready[u]) begin
                    if (mon_idx[u] >= exp_q[u].size()) begin
                        chk(u, "unexpected_transfer", od, -1);
                    end else begin
                        ex = exp_q[u][mon_idx[u]];
                        mon_idx[u]++;
                        chk(u, "xfer_data", od, ex[DATA_W-1:0]);
                        chk(u, "xfer_last", out_last[u], ex[DATA_W]);
                        got[u].push_back(od);
                    end
                end
                stall_prev[u] = out_valid[u] && !out_ready[u];
                hold_d[u]     = od;
                hold_l[u]     = out_last[u];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            case (adc_mode)
                0: adc_data = adc_data + 1'b1;
                1: adc_data = adc_data - 1'b1;
                3: adc_data = DATA_W'($urandom_range(0, 16383));
                default: ;
            endcase
            for (int u = 0; u < 2; u++)
                out_ready[u] = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
        end
    endtask

    task automatic pulse_arm(int u);
        arm[u] = 1'b1;
        cyc(1);
        arm[u] = 1'b0;
    endtask

    task automatic wait_done(int u, int d0, int budget);
        int n = 0;
        while (done_cnt[u] == d0 && n < budget) begin
            cyc(1);
            n++;
        end
        chk(u, "done_within_budget", (done_cnt[u] != d0) ? 1 : 0, 1);
    endtask

    task automatic chk_reset_vals(int u);
        chk(u, "rst_out_valid", out_valid[u], 0);
        chk(u, "rst_out_data", (u == 0) ? out_data0 : out_data1, 0);
        chk(u, "rst_out_last", out_last[u], 0);
        chk(u, "rst_busy", busy[u], 0);
        chk(u, "rst_triggered", triggered[u], 0);
        chk(u, "rst_done", done[u], 0);
    endtask

    // Checks a finished window at got[u][base..]: first, trigger-index and
    // last values plus the window length.
    task automatic chk_window(int u, string tag, int base, int v0, int vt, int vl, int pre);
        chk(u, {tag, "_len"}, got[u].size() - base, DEPTH);
        if (got[u].size() >= base + DEPTH) begin
            chk(u, {tag, "_first"}, got[u][base], v0);
            chk(u, {tag, "_trig_idx"}, got[u][base + pre], vt);
            chk(u, {tag, "_last"}, got[u][base + DEPTH - 1], vl);
        end
    endtask

    initial begin
        int base, d0, v, n, ok;
        reset      = 1'b0;
        adc_data   = '0;
        trig_level = 14'd100;
        trig_slope = 1'b1;
        arm        = '0;
        force_trig = '0;
        out_ready  = 2'b11;
        cyc(3);
        @(negedge clk);
        chk_reset_vals(0);
        chk_reset_vals(1);
        cyc(1);
        reset = 1'b1;

        // Reset in the middle of POST aborts the capture.
        trig_level = 14'd30;
        cyc(2);
        pulse_arm(0);
        n = 0;
        while (!triggered[0] && n < 200) begin
            cyc(1);
            n++;
        end
        chk(0, "pre_abort_triggered", triggered[0], 1);
        cyc(3);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals(0);
        cyc(2);
        reset = 1'b1;

        // Rising trigger on a ramp: window 96..111, trigger sample 100.
        adc_mode   = 0;
        adc_data   = '0;
        trig_level = 14'd100;
        trig_slope = 1'b1;
        cyc(2);
        base = got[0].size();
        d0   = done_cnt[0];
        pulse_arm(0);
        wait_done(0, d0, 400);
        cyc(5);
        chk(0, "rise_done_count", done_cnt[0] - d0, 1);
        chk(0, "rise_triggered_held", triggered[0], 1);
        chk_window(0, "rise", base, 96, 100, 111, PRE0);

        // Falling trigger on a down-ramp from full scale.
        adc_mode   = 1;
        adc_data   = 14'd16383;
        trig_level = 14'd8000;
        trig_slope = 1'b0;
        base = got[0].size();
        d0   = done_cnt[0];
        pulse_arm(0);
        wait_done(0, d0, 9500);
        cyc(3);
        chk_window(0, "fall", base, 8004, 8000, 7989, PRE0);

        // Trigger gating: force during PREFILL is ignored, in WAIT_TRIG it fires.
        adc_mode   = 2;
        adc_data   = 14'd5;
        trig_level = 14'd100;
        trig_slope = 1'b1;
        base = got[0].size();
        d0   = done_cnt[0];
        pulse_arm(0);
        force_trig[0] = 1'b1;
        cyc(2);
        force_trig[0] = 1'b0;
        cyc(4);
        chk(0, "gate_no_trig_in_prefill", triggered[0], 0);
        cyc(2);
        force_trig[0] = 1'b1;
        cyc(1);
        force_trig[0] = 1'b0;
        wait_done(0, d0, 200);
        cyc(2);
        ok = 0;
        for (int i = base; i < got[0].size(); i++) if (got[0][i] == 14'd5) ok++;
        chk(0, "gate_samples_of_5", ok, DEPTH);

        // Backpressure: ~30% ready duty on a ramp capture.
        adc_mode   = 0;
        adc_data   = 14'd200;
        trig_level = 14'd300;
        rdy_pct    = 30;
        base = got[0].size();
        d0   = done_cnt[0];
        pulse_arm(0);
        wait_done(0, d0, 800);
        rdy_pct = 100;
        cyc(2);
        ok = 0;
        for (int i = base + 1; i < got[0].size(); i++) if (got[0][i] == got[0][i-1] + 1'b1) ok++;
        chk(0, "bp_in_order_steps", ok, DEPTH - 1);
        chk_window(0, "bp", base, 296, 300, 311, PRE0);

        // Randomised captures: random data, level, slope and ready duty.
        for (int r = 0; r < 4; r++) begin
            adc_mode   = 3;
            rdy_pct    = $urandom_range(40, 100);
            trig_level = DATA_W'($urandom_range(0, 16383));
            trig_slope = 1'($urandom_range(0, 1));
            d0 = done_cnt[0];
            pulse_arm(0);
            cyc(40);
            force_trig[0] = 1'b1;
            cyc(1);
            force_trig[0] = 1'b0;
            wait_done(0, d0, 600);
            cyc(3);
        end
        rdy_pct = 100;

        // PRE=0: arm then immediate force; arm pulse during READOUT is ignored.
        adc_mode   = 0;
        adc_data   = 14'd1000;
        trig_level = 14'd0;
        trig_slope = 1'b1;
        cyc(2);
        base = got[1].size();
        d0   = done_cnt[1];
        v    = adc_data;
        pulse_arm(1);
        force_trig[1] = 1'b1;
        cyc(1);
        force_trig[1] = 1'b0;
        cyc(22);
        pulse_arm(1);
        wait_done(1, d0, 200);
        cyc(5);
        chk(1, "pre0_done_count", done_cnt[1] - d0, 1);
        chk(1, "pre0_idle_after_ignored_arm", busy[1], 0);
        chk_window(1, "pre0", base, v, v, v + DEPTH - 1, PRE1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
